// File: rtl/resilient_stage_ctrl_pkg.sv
// rtl/resilient_stage_ctrl_pkg.sv - shared types and helpers for the resilient stage controller
package resilient_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        PRE      = 4'd1,
        SAMPLE   = 4'd2,
        DETECT   = 4'd3,
        ERR_REQ  = 4'd4,
        ERR_RTZ  = 4'd5,
        RESAMPLE = 4'd6,
        FWD      = 4'd7,
        RTZ      = 4'd8
    } state_e;

    // Ceiling log2, never below 1 so that derived counters are always at least one bit wide
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/resilient_stage_ctrl_if.sv
// rtl/resilient_stage_ctrl_if.sv - handshake and detector bundle of one resilient pipeline stage
interface resilient_stage_ctrl_if #(
    parameter int N_ERR = 2
) ();
    logic             Lreq;
    logic             Lack;
    logic             Rreq;
    logic             Rack;
    logic             LEreq;
    logic             LEack;
    logic             sample;
    logic [N_ERR-1:0] err;

    // Controller side
    modport master (
        input  Lreq,
        output Lack,
        output Rreq,
        input  Rack,
        output LEreq,
        input  LEack,
        output sample,
        input  err
    );

    // Environment side: neighbouring stages and the error detectors
    modport slave (
        output Lreq,
        input  Lack,
        input  Rreq,
        output Rack,
        input  LEreq,
        output LEack,
        input  sample,
        output err
    );
endinterface

// File: rtl/resilient_stage_ctrl_mode_tracker.sv
// rtl/resilient_stage_ctrl_mode_tracker.sv - error statistics and fast/slow mode selection
module resilient_mode_tracker
    import resilient_ctrl_pkg::*;
#(
    parameter int ERR_THRESH = 2,
    parameter int CLEAN_WIN  = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             token_done_i,
    input  logic             token_err_i,
    output logic             slow_mode_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int RUN_MAX = (ERR_THRESH > CLEAN_WIN) ? ERR_THRESH : CLEAN_WIN;
    localparam int RW      = clog2(RUN_MAX + 1);

    logic [RW-1:0]    cons_q, cons_d;
    logic [RW-1:0]    clean_q, clean_d;
    logic             slow_q, slow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    cons_inc;
    logic [RW-1:0]    clean_inc;

    // Run counters stay below their thresholds, so the increment always fits in RW bits
    assign cons_inc  = cons_q + RW'(1);
    assign clean_inc = clean_q + RW'(1);

    // Per-token bookkeeping: one update on each token_done strobe
    always_comb begin
        cons_d  = cons_q;
        clean_d = clean_q;
        slow_d  = slow_q;
        cnt_d   = cnt_q;
        if (token_done_i) begin
            if (token_err_i) begin
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                clean_d = '0;
                if (cons_inc >= RW'(ERR_THRESH)) begin
                    slow_d = 1'b1;
                    cons_d = '0;
                end else begin
                    cons_d = cons_inc;
                end
            end else begin
                cons_d = '0;
                if (slow_q) begin
                    if (clean_inc >= RW'(CLEAN_WIN)) begin
                        slow_d  = 1'b0;
                        clean_d = '0;
                    end else begin
                        clean_d = clean_inc;
                    end
                end
            end
        end
    end

    // Statistics and mode registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cons_q  <= '0;
            clean_q <= '0;
            slow_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            cons_q  <= cons_d;
            clean_q <= clean_d;
            slow_q  <= slow_d;
            cnt_q   <= cnt_d;
        end
    end

    assign slow_mode_o = slow_q;
    assign err_cnt_o   = cnt_q;

endmodule

// File: rtl/resilient_stage_ctrl.sv
// rtl/resilient_stage_ctrl.sv - handshake, sampling and error-recovery controller for one stage
module resilient_stage_ctrl
    import resilient_ctrl_pkg::*;
#(
    parameter int N_ERR      = 2,
    parameter int DET_LAT    = 1,
    parameter int ERR_THRESH = 2,
    parameter int CLEAN_WIN  = 4,
    parameter int CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    resilient_stage_ctrl_if.master bus,
    output logic                   slow_mode,
    output logic [CNT_W-1:0]       err_cnt
);

    localparam int DW = clog2(DET_LAT + 1);

    state_e           state_q, state_d;
    logic [DW-1:0]    det_cnt_q, det_cnt_d;
    logic             lack_q, lack_d;
    logic             rreq_q, rreq_d;
    logic             lereq_q, lereq_d;
    logic             sample_q, sample_d;
    logic [N_ERR-1:0] err_w;
    logic             any_err;
    logic             det_last;
    logic             token_done;

    assign err_w      = bus.err;
    assign any_err    = |err_w;
    assign det_last   = (state_q == DETECT) && (det_cnt_q == DW'(DET_LAT - 1));
    assign token_done = det_last;

    // State and detect-latency counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            det_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            det_cnt_q <= det_cnt_d;
        end
    end

    // Next-state logic; slow_mode is only consulted when a token starts
    always_comb begin
        state_d   = state_q;
        det_cnt_d = (state_q == DETECT) ? det_cnt_q + DW'(1) : '0;
        case (state_q)
            IDLE:     if (bus.Lreq) state_d = slow_mode ? PRE : SAMPLE;
            PRE:      state_d = SAMPLE;
            SAMPLE:   state_d = DETECT;
            DETECT:   if (det_last) state_d = any_err ? ERR_REQ : FWD;
            ERR_REQ:  if (bus.LEack) state_d = ERR_RTZ;
            ERR_RTZ:  if (!bus.LEack) state_d = RESAMPLE;
            RESAMPLE: state_d = FWD;
            FWD:      if (bus.Rack) state_d = RTZ;
            RTZ:      if (!bus.Rack && !bus.Lreq) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs track the current state
    always_comb begin
        lack_d   = (state_d == FWD) || (state_d == RTZ);
        rreq_d   = (state_d == FWD);
        lereq_d  = (state_d == ERR_REQ);
        sample_d = (state_d == SAMPLE) || (state_d == RESAMPLE);
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            lack_q   <= 1'b0;
            rreq_q   <= 1'b0;
            lereq_q  <= 1'b0;
            sample_q <= 1'b0;
        end else begin
            lack_q   <= lack_d;
            rreq_q   <= rreq_d;
            lereq_q  <= lereq_d;
            sample_q <= sample_d;
        end
    end

    assign bus.Lack   = lack_q;
    assign bus.Rreq   = rreq_q;
    assign bus.LEreq  = lereq_q;
    assign bus.sample = sample_q;

    resilient_mode_tracker #(
        .ERR_THRESH (ERR_THRESH),
        .CLEAN_WIN  (CLEAN_WIN),
        .CNT_W      (CNT_W)
    ) u_tracker (
        .clk          (clk),
        .rst          (rst),
        .token_done_i (token_done),
        .token_err_i  (any_err),
        .slow_mode_o  (slow_mode),
        .err_cnt_o    (err_cnt)
    );

endmodule

// File: tb/tb_resilient_stage_ctrl.sv
// tb/tb_resilient_stage_ctrl.sv - directed self-checking bench for resilient_stage_ctrl
module tb_resilient_stage_ctrl;
    localparam int DET_LAT = 1;

    logic       clk;
    logic       rst;
    logic       slow1;
    logic [7:0] cnt1;
    logic       slow2;
    logic [1:0] cnt2;

    int n_pass;
    int n_total;

    resilient_stage_ctrl_if #(.N_ERR(2)) bus1 ();
    resilient_stage_ctrl_if #(.N_ERR(2)) bus2 ();

    assign bus2.Lreq  = bus1.Lreq;
    assign bus2.Rack  = bus1.Rack;
    assign bus2.LEack = bus1.LEack;
    assign bus2.err   = bus1.err;

    resilient_stage_ctrl #(
        .N_ERR(2), .DET_LAT(DET_LAT), .ERR_THRESH(2), .CLEAN_WIN(4), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus1.master), .slow_mode(slow1), .err_cnt(cnt1)
    );

    resilient_stage_ctrl #(
        .N_ERR(2), .DET_LAT(DET_LAT), .ERR_THRESH(2), .CLEAN_WIN(4), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .bus(bus2.master), .slow_mode(slow2), .err_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus1.Lreq  = 1'b0;
        bus1.Rack  = 1'b0;
        bus1.LEack = 1'b0;
        bus1.err   = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Runs one full token; cycle 0 is the cycle Lreq is first high in IDLE
    task automatic do_token(input logic [1:0] e, output int s_cyc, output int r_cyc,
                            output int le_cyc, output int s_num);
        bit done;
        s_cyc  = -1;
        r_cyc  = -1;
        le_cyc = -1;
        s_num  = 0;
        done   = 1'b0;
        bus1.Lreq = 1'b1;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            tick();
            if (bus1.sample) begin
                s_num++;
                if (s_cyc < 0) s_cyc = cyc;
            end
            bus1.err = (s_cyc >= 0 && cyc == s_cyc + DET_LAT) ? e : 2'b00;
            if (bus1.LEreq && le_cyc < 0) le_cyc = cyc;
            if (bus1.LEreq) bus1.LEack = 1'b1;
            else if (bus1.LEack) bus1.LEack = 1'b0;
            if (bus1.Rreq) begin
                if (r_cyc < 0) r_cyc = cyc;
                bus1.Rack = 1'b1;
                bus1.Lreq = 1'b0;
            end else if (bus1.Rack) begin
                bus1.Rack = 1'b0;
            end
            if (r_cyc >= 0 && !bus1.Lack && !bus1.Rreq && !bus1.Rack) done = 1'b1;
        end
        bus1.err = 2'b00;
        n_total++;
        if (!done) $display("FAIL token_timeout: completed=%0d required=1", done);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({bus1.Lack, bus1.Rreq, bus1.LEreq, bus1.sample, slow1} !== 5'b00000)
            $display("FAIL reset_outputs: got=%b required=00000",
                     {bus1.Lack, bus1.Rreq, bus1.LEreq, bus1.sample, slow1});
        else n_pass++;
        n_total++;
        if (cnt1 !== 8'd0) $display("FAIL reset_err_cnt: got=%0d required=0", cnt1);
        else n_pass++;
    endtask

    task automatic test_clean();
        int s, r, le, sn;
        do_reset();
        do_token(2'b00, s, r, le, sn);
        n_total++;
        if (s !== 1) $display("FAIL clean_sample_cycle: got=%0d required=1", s); else n_pass++;
        n_total++;
        if (r !== 3) $display("FAIL clean_rreq_cycle: got=%0d required=3", r); else n_pass++;
        n_total++;
        if (le !== -1) $display("FAIL clean_lereq: got=%0d required=-1", le); else n_pass++;
        n_total++;
        if (sn !== 1) $display("FAIL clean_sample_count: got=%0d required=1", sn); else n_pass++;
        n_total++;
        if (cnt1 !== 8'd0) $display("FAIL clean_err_cnt: got=%0d required=0", cnt1); else n_pass++;
        n_total++;
        if (bus1.Lack !== 1'b0) $display("FAIL clean_lack_low: got=%b required=0", bus1.Lack); else n_pass++;
    endtask

    task automatic test_error();
        int s, r, le, sn;
        do_reset();
        do_token(2'b10, s, r, le, sn);
        n_total++;
        if (le !== 3) $display("FAIL err_lereq_cycle: got=%0d required=3", le); else n_pass++;
        n_total++;
        if (sn !== 2) $display("FAIL err_sample_count: got=%0d required=2", sn); else n_pass++;
        n_total++;
        if (r !== 6) $display("FAIL err_rreq_cycle: got=%0d required=6", r); else n_pass++;
        n_total++;
        if (cnt1 !== 8'd1) $display("FAIL err_err_cnt: got=%0d required=1", cnt1); else n_pass++;
        n_total++;
        if (slow1 !== 1'b0) $display("FAIL err_slow_mode: got=%b required=0", slow1); else n_pass++;
    endtask

    task automatic test_slow_entry();
        int s, r, le, sn;
        do_reset();
        do_token(2'b01, s, r, le, sn);
        n_total++;
        if (slow1 !== 1'b0) $display("FAIL entry_slow_after1: got=%b required=0", slow1); else n_pass++;
        do_token(2'b10, s, r, le, sn);
        n_total++;
        if (slow1 !== 1'b1) $display("FAIL entry_slow_after2: got=%b required=1", slow1); else n_pass++;
        n_total++;
        if (cnt1 !== 8'd2) $display("FAIL entry_err_cnt: got=%0d required=2", cnt1); else n_pass++;
        do_token(2'b00, s, r, le, sn);
        n_total++;
        if (s !== 2) $display("FAIL slow_sample_cycle: got=%0d required=2", s); else n_pass++;
        n_total++;
        if (r !== 4) $display("FAIL slow_rreq_cycle: got=%0d required=4", r); else n_pass++;
    endtask

    task automatic test_slow_exit();
        int s, r, le, sn;
        logic [3:0] exp_tail;
        do_reset();
        do_token(2'b01, s, r, le, sn);
        do_token(2'b01, s, r, le, sn);
        for (int i = 0; i < 3; i++) begin
            do_token(2'b00, s, r, le, sn);
            n_total++;
            if (slow1 !== 1'b1) $display("FAIL exit_slow_clean%0d: got=%b required=1", i, slow1);
            else n_pass++;
        end
        do_token(2'b11, s, r, le, sn);
        n_total++;
        if (slow1 !== 1'b1) $display("FAIL exit_slow_after_err: got=%b required=1", slow1); else n_pass++;
        n_total++;
        if (cnt1 !== 8'd3) $display("FAIL exit_err_cnt: got=%0d required=3", cnt1); else n_pass++;
        exp_tail = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            do_token(2'b00, s, r, le, sn);
            n_total++;
            if (slow1 !== exp_tail[i])
                $display("FAIL exit_slow_run%0d: got=%b required=%b", i, slow1, exp_tail[i]);
            else n_pass++;
        end
        do_token(2'b00, s, r, le, sn);
        n_total++;
        if (s !== 1) $display("FAIL exit_fast_sample_cycle: got=%0d required=1", s); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int s, r, le, sn;
        int s_cyc;
        bit reached;
        do_reset();
        do_token(2'b10, s, r, le, sn);
        do_token(2'b10, s, r, le, sn);
        s_cyc   = -1;
        reached = 1'b0;
        bus1.Lreq = 1'b1;
        for (int cyc = 1; cyc <= 20 && !reached; cyc++) begin
            tick();
            if (bus1.sample && s_cyc < 0) s_cyc = cyc;
            bus1.err = (s_cyc >= 0 && cyc == s_cyc + DET_LAT) ? 2'b01 : 2'b00;
            if (bus1.LEreq) reached = 1'b1;
        end
        bus1.err = 2'b00;
        n_total++;
        if (!reached) $display("FAIL mid_reach_err_req: got=%b required=1", reached); else n_pass++;
        rst = 1'b1;
        tick();
        n_total++;
        if ({bus1.LEreq, bus1.Lack, bus1.Rreq, bus1.sample, slow1} !== 5'b00000)
            $display("FAIL mid_reset_outputs: got=%b required=00000",
                     {bus1.LEreq, bus1.Lack, bus1.Rreq, bus1.sample, slow1});
        else n_pass++;
        n_total++;
        if (cnt1 !== 8'd0) $display("FAIL mid_reset_err_cnt: got=%0d required=0", cnt1); else n_pass++;
        rst        = 1'b0;
        bus1.Lreq  = 1'b0;
        bus1.LEack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if ({bus1.LEreq, bus1.Lack, bus1.sample} !== 3'b000)
                $display("FAIL mid_ignore_leack%0d: got=%b required=000", i,
                         {bus1.LEreq, bus1.Lack, bus1.sample});
            else n_pass++;
        end
        bus1.LEack = 1'b0;
        tick();
        do_token(2'b00, s, r, le, sn);
        n_total++;
        if (r !== 3) $display("FAIL mid_after_rreq_cycle: got=%0d required=3", r); else n_pass++;
    endtask

    task automatic test_saturation();
        int s, r, le, sn;
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_token(2'b11, s, r, le, sn);
            n_total++;
            if (cnt2 !== exp_seq[i])
                $display("FAIL sat_err_cnt%0d: got=%0d required=%0d", i, cnt2, exp_seq[i]);
            else n_pass++;
        end
        n_total++;
        if (cnt1 !== 8'd5) $display("FAIL sat_wide_err_cnt: got=%0d required=5", cnt1); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst        = 1'b1;
        bus1.Lreq  = 1'b0;
        bus1.Rack  = 1'b0;
        bus1.LEack = 1'b0;
        bus1.err   = 2'b00;
        test_reset();
        test_clean();
        test_error();
        test_slow_entry();
        test_slow_exit();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/resilient_stage_ctrl.md
Name: resilient_stage_ctrl

Overview:
Synchronous, parametrised controller for one timing-resilient pipeline stage. It runs the four-phase left/right handshakes and the error-notify handshake, and issues the stage `sample` pulse. It ORs N_ERR error-detector channels and recovers from errors by notifying upstream and re-sampling. Adaptive mode switching (fast/slow) replaces fixed single-channel error handling and tracks error statistics.

Parameters:
N_ERR, 2, number of error-detector channels on `err`
DET_LAT, 1, cycles from `sample` pulse to valid `err` (>=1)
ERR_THRESH, 2, consecutive errored tokens that force slow mode (>=1)
CLEAN_WIN, 4, consecutive clean tokens in slow mode that restore fast mode (>=1)
CNT_W, 8, width of saturating error counter

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
Lreq  in  1  left request, four-phase level
Lack  out  1  left acknowledge
Rreq  out  1  right request
Rack  in  1  right acknowledge
LEreq  out  1  error-notify request to upstream
LEack  in  1  error-notify acknowledge
sample  out  1  one-cycle capture pulse for stage latches
err  in  N_ERR  per-channel error flags, valid exactly DET_LAT cycles after sample
slow_mode  out  1  1 = slow (pre-wait) timing active
err_cnt  out  CNT_W  saturating count of errored tokens

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset state: state=IDLE. Lack, Rreq, LEreq, sample, slow_mode = 0. err_cnt and internal counters = 0.
- Reset mid-operation (any state): everything returns to reset values at the next edge. A pending handshake is abandoned.
- States and transitions:
  - IDLE: exit when Lreq=1. Go to PRE if slow_mode=1, else to SAMPLE.
  - PRE: one idle cycle, then SAMPLE.
  - SAMPLE: sample=1 for exactly this cycle, then DETECT.
  - DETECT: lasts DET_LAT cycles. any_err = |err, read in the last DETECT cycle. If any_err=1, go to ERR_REQ; else go to FWD.
  - ERR_REQ: LEreq=1; wait for LEack=1, then go to ERR_RTZ.
  - ERR_RTZ: LEreq=0; wait for LEack=0, then go to RESAMPLE.
  - RESAMPLE: sample=1 for one cycle, then FWD. Resampled data is not checked; `err` is ignored.
  - FWD: Lack=1, Rreq=1; wait for Rack=1, then go to RTZ.
  - RTZ: Rreq=0, Lack=1. When Rack=0 and Lreq=0, go to IDLE, where Lack=0.
- Clean-token latency (Lreq seen high in IDLE at cycle 0):
  - sample at cycle 1 (cycle 2 in slow mode).
  - Lack/Rreq rise at cycle 2+DET_LAT (3+DET_LAT in slow mode).
- Lreq held high in RTZ is not a new token. A new token starts only after IDLE is re-entered with Lreq=0 observed first.
- Token accounting (updated on leaving DETECT):
  - Errored token:
    - err_cnt increments, saturating at 2^CNT_W-1.
    - Consecutive-error count increments; the clean count clears.
  - Clean token: the consecutive-error count clears.
    - If slow_mode=1, the clean count increments.
- Mode switching:
  - Consecutive-error count reaching ERR_THRESH: slow_mode=1 from the next edge; both counters clear.
  - In slow mode, clean count reaching CLEAN_WIN: slow_mode=0; both counters clear.
  - A mode change takes effect from the next token; the current token keeps the timing it started with.
- Multiple simultaneous channel errors count as one errored token.
- Consecutive-error and clean counters are clog2(max(ERR_THRESH, CLEAN_WIN)+1) bits wide and never wrap.

Decomposition:
- Package resilient_ctrl_pkg:
  - state enum (IDLE, PRE, SAMPLE, DETECT, ERR_REQ, ERR_RTZ, RESAMPLE, FWD, RTZ);
  - clog2 helper function.
- Sub-module resilient_mode_tracker:
  - consecutive-error and clean counters, slow_mode register, saturating err_cnt;
  - driven by one-cycle token_done/token_err strobes from the main FSM.

Test Plan:
- Clean token, DET_LAT=1, fast mode: Lreq=1 at cycle 0. Expect sample=1 at cycle 1 only, Lack=Rreq=1 at cycle 3, LEreq never 1, err_cnt=0. Then drive Rack=1, Lreq=0, Rack=0; expect Lack=0 and return to IDLE.
- err=2'b10 at cycle 2: expect LEreq=1 at cycle 3. After the LEack 1→0 handshake, expect a second sample pulse, then Rreq=1. err_cnt=1, slow_mode=0.
- Two consecutive errored tokens (ERR_THRESH=2): expect slow_mode=1 after the second. On the third token (Lreq at cycle 0), expect sample at cycle 2 and Rreq at cycle 4.
- In slow mode: three clean tokens, then one errored token, then four clean tokens. Expect slow_mode to stay 1 until the end of the 4th clean token of the final run, then 0.
- Assert rst=1 while in ERR_REQ: at the next edge expect LEreq=Lack=Rreq=sample=slow_mode=0 and err_cnt=0. Ignore LEack afterwards.
- CNT_W=2, five errored tokens with err=2'b11: expect err_cnt sequence 1, 2, 3, 3, 3 (saturation, one count per token).
